// File: rtl/tour_seq.sv
// Knight's-tour command sequencer: replays solved moves as two-leg cmd_proc commands.
// Optional define TOUR_ABORT_EN lets a UART command abort a running tour.
module tour_seq #(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = $clog2(NUM_MOVES),
   parameter bit X_FIRST   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [7:0]       resp,
   output logic             tour_busy,
   output logic             tour_done,
   output logic             move_err
);

   typedef enum logic [2:0] {IDLE, LEG1, HOLD1, LEG2, HOLD2} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
   logic             move_err_q, move_err_d;
   logic             tour_done_q, tour_done_d;
   logic             abort_pend;
   logic             move_ok;
   logic             last_move;
   logic [15:0]      y_cmd, x_cmd, leg1_cmd, leg2_cmd;

   function automatic logic [15:0] y_leg(input logic [7:0] m);
      case (m)
         8'h01, 8'h02: y_leg = 16'h4002;
         8'h04, 8'h80: y_leg = 16'h4001;
         8'h10, 8'h20: y_leg = 16'h47F2;
         8'h08, 8'h40: y_leg = 16'h47F1;
         default:      y_leg = 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] x_leg(input logic [7:0] m);
      case (m)
         8'h40, 8'h80: x_leg = 16'h5BF2;
         8'h01, 8'h20: x_leg = 16'h5BF1;
         8'h04, 8'h08: x_leg = 16'h53F2;
         8'h02, 8'h10: x_leg = 16'h53F1;
         default:      x_leg = 16'h0000;
      endcase
   endfunction

   assign move_ok   = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
   assign last_move = (mv_indx_q == LAST_IDX);
   assign y_cmd     = y_leg(move);
   assign x_cmd     = x_leg(move);
   assign leg1_cmd  = X_FIRST ? x_cmd : y_cmd;
   assign leg2_cmd  = X_FIRST ? y_cmd : x_cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mv_indx_q   <= '0;
         move_err_q  <= 1'b0;
         tour_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mv_indx_q   <= mv_indx_d;
         move_err_q  <= move_err_d;
         tour_done_q <= tour_done_d;
      end
   end

`ifdef TOUR_ABORT_EN
   // Any UART traffic during a tour arms an abort taken at the next move boundary.
   logic abort_q, abort_d;

   always_comb begin
      abort_d = abort_q;
      if (state_q != IDLE && cmd_rdy_UART)
         abort_d = 1'b1;
      if (state_d == IDLE)
         abort_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         abort_q <= 1'b0;
      else
         abort_q <= abort_d;
   end

   assign abort_pend = abort_q;
`else
   assign abort_pend = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mv_indx_d   = mv_indx_q;
      move_err_d  = move_err_q;
      tour_done_d = 1'b0;
      cmd         = cmd_UART;
      cmd_rdy     = 1'b0;
      case (state_q)
         IDLE: begin
            cmd       = cmd_UART;
            cmd_rdy   = cmd_rdy_UART;
            mv_indx_d = '0;
            if (start_tour) begin
               state_d    = LEG1;
               move_err_d = 1'b0;
            end
         end
         LEG1: begin
            cmd = leg1_cmd;
            if (!move_ok) begin
               move_err_d = 1'b1;
               mv_indx_d  = '0;
               state_d    = IDLE;
            end else begin
               cmd_rdy = 1'b1;
               if (clr_cmd_rdy)
                  state_d = HOLD1;
            end
         end
         HOLD1: begin
            cmd = leg1_cmd;
            if (send_resp)
               state_d = LEG2;
         end
         LEG2: begin
            cmd     = leg2_cmd;
            cmd_rdy = 1'b1;
            if (clr_cmd_rdy)
               state_d = HOLD2;
         end
         HOLD2: begin
            cmd = leg2_cmd;
            if (send_resp) begin
               if (last_move || abort_pend) begin
                  state_d     = IDLE;
                  mv_indx_d   = '0;
                  tour_done_d = !abort_pend;
               end else begin
                  state_d   = LEG1;
                  mv_indx_d = mv_indx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The final move reports "done" as soon as its first leg has been accepted.
   assign resp = ((state_q == IDLE) ||
                  (last_move && (state_q == HOLD1 || state_q == LEG2 || state_q == HOLD2)))
                 ? 8'hA5 : 8'h5A;

   assign mv_indx   = mv_indx_q;
   assign tour_busy = (state_q != IDLE);
   assign tour_done = tour_done_q;
   assign move_err  = move_err_q;

endmodule

// File: tb/tb_tour_seq.sv
// Self-checking bench for tour_seq: randomized tours compared against a move-table reference model.
// Expectations follow TOUR_ABORT_EN when it is defined for the build.
module tb_tour_seq;

   localparam int NUM = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour, start2;
   logic [7:0]  move, move2;
   logic [4:0]  mv_indx;
   logic [1:0]  mv_indx2;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic [15:0] cmd, cmd2;
   logic        cmd_rdy, cmd_rdy2;
   logic        clr_cmd_rdy, send_resp;
   logic [7:0]  resp, resp2;
   logic        tour_busy, tour_busy2;
   logic        tour_done, tour_done2;
   logic        move_err, move_err2;

   logic [7:0]  mem [NUM];
   logic [15:0] yTab [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                             16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
   logic [15:0] xTab [8] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                             16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   // The move memory answers combinationally at the address the sequencer presents.
   assign move  = mem[mv_indx];
   assign move2 = 8'h80;

   tour_seq #(.NUM_MOVES(NUM)) dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
      .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
      .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .resp(resp), .tour_busy(tour_busy),
      .tour_done(tour_done), .move_err(move_err)
   );

   tour_seq #(.NUM_MOVES(4), .X_FIRST(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_tour(start2), .move(move2),
      .mv_indx(mv_indx2), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
      .cmd(cmd2), .cmd_rdy(cmd_rdy2), .clr_cmd_rdy(clr_cmd_rdy),
      .send_resp(send_resp), .resp(resp2), .tour_busy(tour_busy2),
      .tour_done(tour_done2), .move_err(move_err2)
   );

   // Reference model: leg commands looked up by the position of the single set bit.
   function automatic logic [15:0] yExp(input logic [7:0] m);
      for (int b = 0; b < 8; b++)
         if (m[b]) return yTab[b];
      return 16'h0000;
   endfunction

   function automatic logic [15:0] xExp(input logic [7:0] m);
      for (int b = 0; b < 8; b++)
         if (m[b]) return xTab[b];
      return 16'h0000;
   endfunction

   // Expected response for move i once its first leg has been accepted.
   function automatic logic [7:0] respExp(input int i);
      return (i == NUM - 1) ? 8'hA5 : 8'h5A;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of handshake inputs, then returns 1 time unit past the edge.
   task automatic applyStimulus(input logic st, input logic clr, input logic sr);
      start_tour  = st;
      clr_cmd_rdy = clr;
      send_resp   = sr;
      @(posedge clk);
      #1;
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
   endtask

   task automatic fillRandom();
      for (int i = 0; i < NUM; i++)
         mem[i] = 8'h01 << $urandom_range(0, 7);
   endtask

   // Runs one tour. abortAt raises cmd_rdy_UART from that move on; errAt expects an
   // illegal move there; rstAt asserts reset in HOLD1 of that move. -1 disables each.
   task automatic runTour(input int abortAt, input int errAt, input int rstAt);
      bit abortOn, last, doneExp;
      doneExp = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("moveErrClearOnStart", move_err, 0);
      for (int i = 0; i < NUM; i++) begin
         last = (i == NUM - 1);
         if (i == errAt) begin
            checkOutput("errNoCmdRdy", cmd_rdy, 0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("errFlag", move_err, 1);
            checkOutput("errIdle", tour_busy, 0);
            checkOutput("errNoDone", tour_done, 0);
            checkOutput("errIdx", mv_indx, 0);
            return;
         end
         checkOutput("leg1Busy", tour_busy, 1);
         checkOutput("leg1Idx", mv_indx, 32'(i));
         checkOutput("leg1Rdy", cmd_rdy, 1);
         checkOutput("leg1Cmd", cmd, yExp(mem[i]));
         checkOutput("leg1Resp", resp, 8'h5A);
         checkOutput("noEarlyDone", tour_done, 0);
         if (i == abortAt) begin
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'b1;
         end
         applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         checkOutput("hold1Rdy", cmd_rdy, 0);
         checkOutput("hold1Cmd", cmd, yExp(mem[i]));
         checkOutput("hold1Resp", resp, respExp(i));
         if (i == rstAt) begin
            cmd_UART     = 16'($urandom);
            cmd_rdy_UART = 1'b1;
            rst_n = 1'b0;
            #1;
            checkOutput("rstIdle", tour_busy, 0);
            checkOutput("rstIdx", mv_indx, 0);
            checkOutput("rstRdyUart", cmd_rdy, 1);
            checkOutput("rstCmdUart", cmd, cmd_UART);
            checkOutput("rstResp", resp, 8'hA5);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            cmd_rdy_UART = 1'b0;
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("rstNoDone", tour_done, 0);
            checkOutput("rstStayIdle", tour_busy, 0);
            return;
         end
         if ($urandom_range(0, 1) == 1) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("strayClrHold1", cmd_rdy, 0);
            checkOutput("strayClrCmd", cmd, yExp(mem[i]));
         end
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("leg2Rdy", cmd_rdy, 1);
         checkOutput("leg2Cmd", cmd, xExp(mem[i]));
         checkOutput("leg2Resp", resp, respExp(i));
         applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0);
         checkOutput("hold2Rdy", cmd_rdy, 0);
         checkOutput("hold2Cmd", cmd, xExp(mem[i]));
         checkOutput("hold2Idx", mv_indx, 32'(i));
         checkOutput("hold2Busy", tour_busy, 1);
         applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef TOUR_ABORT_EN
         abortOn = (abortAt >= 0) && (i >= abortAt);
`else
         abortOn = 1'b0;
`endif
         doneExp = last && !abortOn;
         if (last || abortOn) break;
      end
      checkOutput("endIdle", tour_busy, 0);
      checkOutput("endIdx", mv_indx, 0);
      checkOutput("endDone", tour_done, 32'(doneExp));
      checkOutput("endResp", resp, 8'hA5);
      checkOutput("endRdyUart", cmd_rdy, 32'(cmd_rdy_UART));
      checkOutput("endCmdUart", cmd, cmd_UART);
      cmd_rdy_UART = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("donePulseOnce", tour_done, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      start_tour   = 1'b0;
      start2       = 1'b0;
      clr_cmd_rdy  = 1'b0;
      send_resp    = 1'b0;
      cmd_UART     = 16'h1234;
      cmd_rdy_UART = 1'b1;
      for (int i = 0; i < NUM; i++) mem[i] = 8'h01;

      // Reset state and UART pass-through in IDLE.
      #2;
      checkOutput("rstBusy", tour_busy, 0);
      checkOutput("rstMvIndx", mv_indx, 0);
      checkOutput("rstMoveErr", move_err, 0);
      checkOutput("rstTourDone", tour_done, 0);
      checkOutput("rstResp", resp, 8'hA5);
      checkOutput("rstCmdRdy", cmd_rdy, 1);
      checkOutput("rstCmd", cmd, 16'h1234);
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      cmd_rdy_UART = 1'b0;
      #1;
      checkOutput("idleRdyFollows", cmd_rdy, 0);

      // All-0x01 tour, then randomized tours with the various disturbances.
      runTour(-1, -1, -1);
      fillRandom();
      runTour(-1, -1, -1);
      fillRandom();
      runTour(3, -1, -1);
      fillRandom();
      mem[5] = 8'h03;
      runTour(-1, 5, -1);
      mem[5] = 8'h10;
      mem[0] = 8'h00;
      runTour(-1, 0, -1);
      mem[0] = 8'h04;
      runTour(-1, -1, 10);
      runTour(-1, -1, -1);

      // X-first instance: move 0x80 issues the X leg before the Y leg.
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      checkOutput("xfLeg1Cmd", cmd2, 16'h5BF2);
      checkOutput("xfLeg1Rdy", cmd_rdy2, 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("xfHold1Cmd", cmd2, 16'h5BF2);
      checkOutput("xfHold1Rdy", cmd_rdy2, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("xfLeg2Cmd", cmd2, 16'h4001);
      checkOutput("xfLeg2Rdy", cmd_rdy2, 1);
      checkOutput("xfIdx", mv_indx2, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
